// File: rtl/sap_pkg.sv
// Shared types and default sizes for the SAP-1 style core.
package sap_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 4;

  typedef enum logic [3:0] {
    OpNop = 4'h0,
    OpLda = 4'h1,
    OpAdd = 4'h2,
    OpSub = 4'h3,
    OpSta = 4'h4,
    OpLdi = 4'h5,
    OpJmp = 4'h6,
    OpJc  = 4'h7,
    OpJz  = 4'h8,
    OpOut = 4'hE,
    OpHlt = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    StT0 = 3'd0,
    StT1 = 3'd1,
    StT2 = 3'd2,
    StT3 = 3'd3,
    StT4 = 3'd4
  } step_e;

  // Bit positions of the one-hot bus source select.
  localparam int unsigned NumBusSrc = 5;
  localparam int unsigned SelPc     = 0;
  localparam int unsigned SelRam    = 1;
  localparam int unsigned SelOpnd   = 2;
  localparam int unsigned SelA      = 3;
  localparam int unsigned SelAlu    = 4;

endpackage

// File: rtl/sap_core_if.sv
// Control/program/status bundle between the SAP core and its host.
interface sap_core_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              step_en;
  logic              prog_mode;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              halted;
  logic              flag_c;
  logic              flag_z;
  logic [ADDR_W-1:0] pc_out;

  modport master (
    output step_en, prog_mode, prog_we, prog_addr, prog_data,
    input  out_data, out_valid, halted, flag_c, flag_z, pc_out
  );

  modport slave (
    input  step_en, prog_mode, prog_we, prog_addr, prog_data,
    output out_data, out_valid, halted, flag_c, flag_z, pc_out
  );
endinterface

// File: rtl/sap_ram.sv
// Program/data RAM: async read, sync write, write port owned by the host in prog mode.
module sap_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              prog_mode_i,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [DATA_W-1:0] prog_data_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);
  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    we    = prog_mode_i ? prog_we_i   : core_we_i;
    waddr = prog_mode_i ? prog_addr_i : core_addr_i;
    wdata = prog_mode_i ? prog_data_i : core_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/sap_core.sv
// SAP-1 style accumulator core: 5-step microcode, one-hot bus mux, program port RAM.
module sap_core
  import sap_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic     clk,
  input  logic     rst,
  sap_core_if.slave bus
);
  logic [ADDR_W-1:0] pc_q, mar_q;
  logic [DATA_W-1:0] a_q, b_q, ir_q, out_data_q;
  step_e             step_q, step_d;
  logic              flag_c_q, flag_z_q, halted_q, out_valid_q;

  logic [NumBusSrc-1:0] bus_sel;
  logic [DATA_W-1:0]    bus_val, ram_rd, pc_ext, opnd_ext;
  logic [DATA_W:0]      alu_res;
  logic                 alu_c, is_sub, advance;
  logic mar_ld, ir_ld, pc_inc, pc_ld, a_ld, b_ld, out_ld, flags_ld, ram_we, hlt_set;
  opcode_e              op;

  // Reset also gates advance so an interrupted STA never reaches the RAM.
  assign advance  = !rst && bus.step_en && !bus.prog_mode && !halted_q;
  assign op       = opcode_e'(ir_q[DATA_W-1 -: 4]);
  assign pc_ext   = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
  assign opnd_ext = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
  assign is_sub   = (op == OpSub);

  always_comb begin
    alu_res = is_sub ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});
    alu_c   = is_sub ? ~alu_res[DATA_W] : alu_res[DATA_W];
  end

  assign bus_val = ({DATA_W{bus_sel[SelPc]}}   & pc_ext)
                 | ({DATA_W{bus_sel[SelRam]}}  & ram_rd)
                 | ({DATA_W{bus_sel[SelOpnd]}} & opnd_ext)
                 | ({DATA_W{bus_sel[SelA]}}    & a_q)
                 | ({DATA_W{bus_sel[SelAlu]}}  & alu_res[DATA_W-1:0]);

  always_comb begin
    bus_sel = '0;
    mar_ld = 1'b0; ir_ld = 1'b0; pc_inc = 1'b0; pc_ld = 1'b0; a_ld = 1'b0;
    b_ld = 1'b0; out_ld = 1'b0; flags_ld = 1'b0; ram_we = 1'b0; hlt_set = 1'b0;
    step_d = step_q;
    if (advance) begin
      step_d = (step_q == StT4) ? StT0 : step_e'(step_q + 3'd1);
      case (step_q)
        StT0: begin bus_sel[SelPc] = 1'b1; mar_ld = 1'b1; end
        StT1: begin bus_sel[SelRam] = 1'b1; ir_ld = 1'b1; pc_inc = 1'b1; end
        StT2: begin
          case (op)
            OpLda, OpAdd, OpSub, OpSta: begin bus_sel[SelOpnd] = 1'b1; mar_ld = 1'b1; end
            OpLdi: begin bus_sel[SelOpnd] = 1'b1; a_ld = 1'b1; end
            OpOut: begin bus_sel[SelA] = 1'b1; out_ld = 1'b1; end
            OpJmp: begin bus_sel[SelOpnd] = 1'b1; pc_ld = 1'b1; end
            OpJc:  begin bus_sel[SelOpnd] = flag_c_q; pc_ld = flag_c_q; end
            OpJz:  begin bus_sel[SelOpnd] = flag_z_q; pc_ld = flag_z_q; end
            OpHlt: hlt_set = 1'b1;
            default: ;
          endcase
        end
        StT3: begin
          case (op)
            OpLda: begin bus_sel[SelRam] = 1'b1; a_ld = 1'b1; end
            OpAdd, OpSub: begin bus_sel[SelRam] = 1'b1; b_ld = 1'b1; end
            OpSta: begin bus_sel[SelA] = 1'b1; ram_we = 1'b1; end
            default: ;
          endcase
        end
        StT4: begin
          if (op == OpAdd || op == OpSub) begin
            bus_sel[SelAlu] = 1'b1; a_ld = 1'b1; flags_ld = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0; mar_q <= '0; a_q <= '0; b_q <= '0; ir_q <= '0;
      step_q <= StT0; flag_c_q <= 1'b0; flag_z_q <= 1'b0; halted_q <= 1'b0;
      out_data_q <= '0; out_valid_q <= 1'b0;
    end else begin
      step_q      <= step_d;
      out_valid_q <= out_ld;
      if (mar_ld)   mar_q      <= bus_val[ADDR_W-1:0];
      if (ir_ld)    ir_q       <= bus_val;
      if (pc_ld)    pc_q       <= bus_val[ADDR_W-1:0];
      else if (pc_inc) pc_q    <= pc_q + ADDR_W'(1);
      if (a_ld)     a_q        <= bus_val;
      if (b_ld)     b_q        <= bus_val;
      if (out_ld)   out_data_q <= bus_val;
      if (hlt_set)  halted_q   <= 1'b1;
      if (flags_ld) begin
        flag_c_q <= alu_c;
        flag_z_q <= (alu_res[DATA_W-1:0] == '0);
      end
    end
  end

  sap_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk_i       (clk),
    .prog_mode_i (bus.prog_mode),
    .prog_we_i   (bus.prog_we),
    .prog_addr_i (bus.prog_addr),
    .prog_data_i (bus.prog_data),
    .core_we_i   (ram_we),
    .core_addr_i (mar_q),
    .core_data_i (bus_val),
    .rd_addr_i   (mar_q),
    .rd_data_o   (ram_rd)
  );

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.halted    = halted_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.pc_out    = pc_q;
endmodule

// File: tb/tb_sap_core.sv
// Directed bench for sap_core: small hand-assembled programs with hand-computed results.
module tb_sap_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;
  int   pulses;
  logic [7:0] img [16];

  sap_core_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  sap_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
  endtask

  task automatic load_img();
    bus.prog_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = 4'(i);
      bus.prog_data = img[i];
      @(negedge clk);
    end
    bus.prog_we   = 1'b0;
    bus.prog_mode = 1'b0;
  endtask

  task automatic run_steps(input int n);
    bus.step_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    bus.step_en = 1'b0;
  endtask

  initial begin
    bus.step_en = 1'b0; bus.prog_mode = 1'b0; bus.prog_we = 1'b0;
    bus.prog_addr = '0; bus.prog_data = '0;
    @(negedge clk);
    do_reset();
    chk("rst_pc", 32'(bus.pc_out), 0);
    chk("rst_out", 32'(bus.out_data), 0);
    chk("rst_halt", 32'(bus.halted), 0);
    chk("rst_flags", {30'd0, bus.flag_c, bus.flag_z}, 0);

    // LDA 14, ADD 15, OUT, HLT
    clear_img();
    img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
    img[14] = 8'd28; img[15] = 8'd14;
    load_img(); do_reset(); pulses = 0;
    run_steps(17);
    chk("add_not_halted_17", 32'(bus.halted), 0);
    run_steps(1);
    chk("add_halted_18", 32'(bus.halted), 1);
    chk("add_out", 32'(bus.out_data), 42);
    chk("add_pc", 32'(bus.pc_out), 4);
    run_steps(4);
    chk("add_pulses", 32'(pulses), 1);
    chk("add_pc_frozen", 32'(bus.pc_out), 4);

    // LDA 14, ADD 15, JC 6 ; 6: OUT, HLT
    clear_img();
    img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h76; img[6] = 8'hE0; img[7] = 8'hF0;
    img[14] = 8'd200; img[15] = 8'd56;
    load_img(); do_reset(); pulses = 0;
    run_steps(15);
    chk("jc_pc", 32'(bus.pc_out), 6);
    chk("jc_flags", {30'd0, bus.flag_c, bus.flag_z}, 3);
    run_steps(10);
    chk("jc_out_a", 32'(bus.out_data), 0);
    chk("jc_pulses", 32'(pulses), 1);
    chk("jc_halt", 32'(bus.halted), 1);

    // LDI 5, SUB 15, JC 0, OUT, HLT
    clear_img();
    img[0] = 8'h55; img[1] = 8'h3F; img[2] = 8'h70; img[3] = 8'hE0; img[4] = 8'hF0;
    img[15] = 8'd6;
    load_img(); do_reset(); pulses = 0;
    run_steps(15);
    chk("sub_pc_not_taken", 32'(bus.pc_out), 3);
    chk("sub_flags", {30'd0, bus.flag_c, bus.flag_z}, 0);
    run_steps(10);
    chk("sub_out", 32'(bus.out_data), 255);
    chk("sub_halt", 32'(bus.halted), 1);

    // All-NOP: PC wraps, step_en=0 stalls mid-instruction
    clear_img();
    load_img(); do_reset();
    for (int k = 1; k <= 17; k++) begin
      run_steps(5);
      chk($sformatf("nop_pc_%0d", k), 32'(bus.pc_out), 32'(k % 16));
    end
    run_steps(2);
    chk("nop_pc_t1", 32'(bus.pc_out), 2);
    repeat (7) @(negedge clk);
    chk("nop_stall_pc", 32'(bus.pc_out), 2);
    run_steps(3);
    chk("nop_after_stall", 32'(bus.pc_out), 2);
    run_steps(2);
    chk("nop_next_fetch", 32'(bus.pc_out), 3);

    // LDA 14, OUT, ADD 15, OUT, HLT with reset at T3 of ADD
    clear_img();
    img[0] = 8'h1E; img[1] = 8'hE0; img[2] = 8'h2F; img[3] = 8'hE0; img[4] = 8'hF0;
    img[14] = 8'd28; img[15] = 8'd14;
    load_img(); do_reset(); pulses = 0;
    run_steps(13);
    chk("mid_out", 32'(bus.out_data), 28);
    chk("mid_pc", 32'(bus.pc_out), 3);
    bus.step_en = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.step_en = 1'b0;
    chk("mid_rst_out", 32'(bus.out_data), 0);
    chk("mid_rst_pc", 32'(bus.pc_out), 0);
    chk("mid_rst_misc", {28'd0, bus.out_valid, bus.halted, bus.flag_c, bus.flag_z}, 0);
    pulses = 0;
    run_steps(23);
    chk("rerun_out", 32'(bus.out_data), 42);
    chk("rerun_pulses", 32'(pulses), 2);
    chk("rerun_halt", 32'(bus.halted), 1);

    // LDI 9, STA 12, NOP, [3]<-OUT via prog port, LDI 0, LDA 12, OUT, HLT
    clear_img();
    img[0] = 8'h59; img[1] = 8'h4C; img[4] = 8'h50; img[5] = 8'h1C;
    img[6] = 8'hE0; img[7] = 8'hF0;
    load_img(); do_reset(); pulses = 0;
    run_steps(7);
    bus.step_en = 1'b1; bus.prog_mode = 1'b1;
    bus.prog_we = 1'b1; bus.prog_addr = 4'd3; bus.prog_data = 8'hE0;
    @(negedge clk);
    bus.prog_we = 1'b0;
    repeat (3) @(negedge clk);
    chk("freeze_pc", 32'(bus.pc_out), 2);
    chk("freeze_halt", 32'(bus.halted), 0);
    bus.prog_mode = 1'b0; bus.step_en = 1'b0;
    run_steps(2);
    // Write strobe outside prog mode must not clobber the stored 9.
    bus.prog_we = 1'b1; bus.prog_addr = 4'd12; bus.prog_data = 8'h77;
    @(negedge clk);
    bus.prog_we = 1'b0;
    run_steps(29);
    chk("sta_out", 32'(bus.out_data), 9);
    chk("sta_pulses", 32'(pulses), 2);
    chk("sta_halt", 32'(bus.halted), 1);
    chk("sta_pc", 32'(bus.pc_out), 8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
